// File: rtl/usb_rcv_control.sv
// Receive-side control FSM for the USB full-speed receiver: gates the decoder,
// validates SYNC, strobes data bytes into the FIFO and classifies EOP/errors.
module usb_rcv_control #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       packet_done,
  output logic [6:0] byte_count
);

  localparam logic [6:0] MAX_B = 7'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE, SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_2, DONE, ERR_WAIT, ERR_IDLE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] byte_count_q, byte_count_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       r_error_q, r_error_d;
  logic       packet_done_q, packet_done_d;
  logic       se;

  assign se = eop & shift_enable;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_count_d = byte_count_q;
    case (state_q)
      IDLE, ERR_IDLE: begin
        if (d_edge) begin
          state_d      = SYNC_WAIT;
          byte_count_d = '0;
        end
      end
      SYNC_WAIT: begin
        if (se)                 state_d = ERR_WAIT;
        else if (byte_received) state_d = SYNC_CHECK;
      end
      SYNC_CHECK: begin
        bit_cnt_d = '0;
        state_d   = (rcv_data == 8'h80) ? DATA_WAIT : ERR_WAIT;
      end
      DATA_WAIT: begin
        // byte_received realigns the bit counter even if a shift coincides
        if (byte_received)     bit_cnt_d = '0;
        else if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
        if (se && bit_cnt_q == 3'd0 && !byte_received) state_d = EOP_2;
        else if (se)                                    state_d = ERR_WAIT;
        else if (byte_received && byte_count_q == MAX_B) state_d = ERR_WAIT;
        else if (byte_received)                          state_d = STORE;
      end
      STORE: begin
        byte_count_d = byte_count_q + 7'd1;
        bit_cnt_d    = '0;
        state_d      = DATA_WAIT;
      end
      EOP_2: begin
        if (shift_enable) state_d = (eop && byte_count_q != 7'd0) ? DONE : ERR_IDLE;
      end
      DONE:     state_d = IDLE;
      ERR_WAIT: if (se) state_d = ERR_IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_comb begin
    rcving_d      = state_d inside {SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_2, ERR_WAIT};
    w_enable_d    = (state_d == STORE);
    packet_done_d = (state_d == DONE);
    r_error_d     = state_d inside {ERR_WAIT, ERR_IDLE};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      byte_count_q  <= '0;
      rcving_q      <= 1'b0;
      w_enable_q    <= 1'b0;
      r_error_q     <= 1'b0;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_count_q  <= byte_count_d;
      rcving_q      <= rcving_d;
      w_enable_q    <= w_enable_d;
      r_error_q     <= r_error_d;
      packet_done_q <= packet_done_d;
    end
  end

  assign rcving      = rcving_q;
  assign w_enable    = w_enable_q;
  assign r_error     = r_error_q;
  assign packet_done = packet_done_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_usb_rcv_control.sv
// Scoreboard bench for usb_rcv_control: stimulus pushes expected write/done/error
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_usb_rcv_control;
  localparam int MB = 4;

  logic       clk = 1'b0, n_rst = 1'b0;
  logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       rcving, w_enable, r_error, packet_done;
  logic [6:0] byte_count;

  usb_rcv_control #(.MAX_BYTES(MB)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received), .rcv_data(rcv_data),
    .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .packet_done(packet_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_W = 2'd1, EV_D = 2'd2, EV_E = 2'd3;
  typedef struct packed { logic [1:0] kind; logic [7:0] val; } ev_t;
  ev_t expq[$];
  int  passed = 0, total = 0;
  logic rerr_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] v);
    expq.push_back('{kind: k, val: v});
  endtask

  task automatic mon_ev(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    if (expq.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d val 0x%02h expected none", k, v);
    end else begin
      e = expq.pop_front();
      check("event_kind_val", int'({k, v}), int'({e.kind, e.val}));
    end
  endtask

  // Monitor: sample away from the active edge
  always @(negedge clk) begin
    if (w_enable)             mon_ev(EV_W, rcv_data);
    if (packet_done)          mon_ev(EV_D, {1'b0, byte_count});
    if (r_error && !rerr_prev) mon_ev(EV_E, {1'b0, byte_count});
    rerr_prev <= r_error;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1; tick(); d_edge = 1'b0;
  endtask

  task automatic send_bits(input int n);
    repeat (n) begin
      shift_enable = 1'b1; tick(); shift_enable = 1'b0;
      repeat (7) tick();
    end
  endtask

  // Last bit's shift coincides with byte_received; rcv_data held afterwards
  task automatic byte_strobe(input logic [7:0] b);
    send_bits(7);
    shift_enable = 1'b1; byte_received = 1'b1; rcv_data = b;
    tick();
    shift_enable = 1'b0; byte_received = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_strobe(b);
    repeat (7) tick();
  endtask

  task automatic se_pulse();
    shift_enable = 1'b1; tick(); shift_enable = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    check(name, expq.size(), 0);
  endtask

  initial begin
    do_reset();
    check("rst_rcving", rcving, 0);
    check("rst_w_enable", w_enable, 0);
    check("rst_r_error", r_error, 0);
    check("rst_packet_done", packet_done, 0);
    check("rst_byte_count", byte_count, 0);

    // Clean packet
    pulse_edge();
    check("clean_rcving_up", rcving, 1);
    send_byte(8'h80);
    push(EV_W, 8'hC3); send_byte(8'hC3);
    push(EV_W, 8'h12); send_byte(8'h12);
    push(EV_W, 8'h34); send_byte(8'h34);
    check("clean_byte_count", byte_count, 3);
    eop = 1'b1;
    se_pulse();
    check("clean_eop2_rcving", rcving, 1);
    repeat (7) tick();
    push(EV_D, 8'd3);
    se_pulse();
    eop = 1'b0;
    check("clean_rcving_drop", rcving, 0);
    check("clean_r_error", r_error, 0);
    tick();
    check("clean_idle_rcving", rcving, 0);
    drain("clean_queue_empty");

    // Bad SYNC
    do_reset();
    pulse_edge();
    push(EV_E, 8'd0);
    byte_strobe(8'h81);
    check("badsync_err_n1", r_error, 0);
    tick();
    check("badsync_err_n2", r_error, 1);
    check("badsync_rcving", rcving, 1);
    repeat (6) tick();
    eop = 1'b1; se_pulse(); eop = 1'b0;
    check("badsync_rcving_off", rcving, 0);
    check("badsync_err_sticky", r_error, 1);
    pulse_edge();
    check("badsync_err_clear", r_error, 0);
    check("badsync_rcving_new", rcving, 1);
    drain("badsync_queue_empty");

    // Mid-byte EOP
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    push(EV_W, 8'hAA); send_byte(8'hAA);
    send_bits(3);
    push(EV_E, 8'd1);
    eop = 1'b1; se_pulse();
    check("midbyte_rcving", rcving, 1);
    check("midbyte_err", r_error, 1);
    repeat (7) tick();
    se_pulse(); eop = 1'b0;
    check("midbyte_rcving_off", rcving, 0);
    check("midbyte_byte_count", byte_count, 1);
    drain("midbyte_queue_empty");

    // Overflow at MAX_BYTES
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    for (int i = 1; i <= 4; i++) begin
      push(EV_W, 8'(i)); send_byte(8'(i));
    end
    push(EV_E, 8'd4);
    send_byte(8'h05);
    check("ovf_byte_count", byte_count, 4);
    check("ovf_err", r_error, 1);
    drain("ovf_queue_empty");

    // Single-bit SE0
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    push(EV_W, 8'h55); send_byte(8'h55);
    eop = 1'b1; se_pulse(); eop = 1'b0;
    check("se0_eop2_rcving", rcving, 1);
    repeat (7) tick();
    push(EV_E, 8'd1);
    se_pulse();
    check("se0_rcving_off", rcving, 0);
    check("se0_err", r_error, 1);
    check("se0_byte_count", byte_count, 1);
    drain("se0_queue_empty");

    // SYNC immediately followed by EOP
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    eop = 1'b1; se_pulse();
    repeat (7) tick();
    push(EV_E, 8'd0);
    se_pulse(); eop = 1'b0;
    check("empty_err", r_error, 1);
    check("empty_rcving", rcving, 0);
    check("empty_byte_count", byte_count, 0);
    drain("empty_queue_empty");

    // Reset during STORE, then a normal packet
    do_reset();
    pulse_edge();
    send_byte(8'h80);
    push(EV_W, 8'h11); send_byte(8'h11);
    byte_strobe(8'h22);
    check("rstmid_store_w", w_enable, 1);
    check("rstmid_pre_count", byte_count, 1);
    n_rst = 1'b0;
    #1;
    check("rstmid_w_enable", w_enable, 0);
    check("rstmid_rcving", rcving, 0);
    check("rstmid_r_error", r_error, 0);
    check("rstmid_byte_count", byte_count, 0);
    tick();
    n_rst = 1'b1;
    tick();
    pulse_edge();
    send_byte(8'h80);
    push(EV_W, 8'h5A); send_byte(8'h5A);
    eop = 1'b1; se_pulse();
    repeat (7) tick();
    push(EV_D, 8'd1);
    se_pulse(); eop = 1'b0;
    check("rstmid_after_err", r_error, 0);
    drain("rstmid_queue_empty");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/usb_rcv_control.md
# usb_rcv_control

Receive-side control FSM for the USB full-speed packet receiver. It gates the NRZI decoder through `rcving`, checks the SYNC byte, and issues one-cycle FIFO write strobes for each received data byte. It detects EOP, counts bytes, and flags framing, SYNC and length errors. It sits between the edge detector, EOP detector, decoder and shift register on one side and the receive FIFO and top-level status on the other.

## Interface
Parameters:
- MAX_BYTES, 64, maximum data bytes per packet after SYNC (PID included); range 1..127

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- d_edge  input  1  one-cycle pulse on any bus transition
- eop  input  1  SE0 detected on the bus (level)
- shift_enable  input  1  one-cycle pulse at each bit-sample point
- byte_received  input  1  one-cycle pulse when the shift register holds 8 new bits
- rcv_data  input  8  current shift-register byte
- rcving  output  1  packet reception in progress; drives the decoder's `rcving` input, which holds the decoder in idle-J when low
- w_enable  output  1  one-cycle FIFO write strobe for `rcv_data`
- r_error  output  1  receive error flag (sticky until the next packet starts)
- packet_done  output  1  one-cycle pulse on a clean EOP
- byte_count  output  7  data bytes stored in the current packet

## Operation
- States: IDLE, SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_2, DONE, ERR_WAIT, ERR_IDLE.
- Outputs are Moore-decoded from the state:
  - rcving = 1 in SYNC_WAIT, SYNC_CHECK, DATA_WAIT, STORE, EOP_2 and ERR_WAIT.
  - w_enable = 1 only in STORE.
  - packet_done = 1 only in DONE.
  - r_error = 1 in ERR_WAIT and ERR_IDLE.
- "se" denotes eop && shift_enable.
- IDLE: d_edge -> SYNC_WAIT.
- SYNC_WAIT: entry clears byte_count to 0. se -> ERR_WAIT. Otherwise byte_received -> SYNC_CHECK.
- SYNC_CHECK: one cycle. rcv_data == 8'h80 -> DATA_WAIT; any other value -> ERR_WAIT.
- DATA_WAIT:
  - Internal 3-bit bit_cnt is cleared on entry from SYNC_CHECK and from STORE.
  - bit_cnt increments on each shift_enable; byte_received forces it to 0 (byte_received wins).
  - Priority order:
    1. se with bit_cnt == 0 and no byte_received -> EOP_2.
    2. se otherwise -> ERR_WAIT (SE0 mid-byte).
    3. byte_received with byte_count == MAX_BYTES -> ERR_WAIT (overflow, no write).
    4. byte_received -> STORE.
- STORE: one cycle with w_enable = 1; byte_count increments; then -> DATA_WAIT.
- EOP_2 waits for the next shift_enable:
  - eop = 1 and byte_count >= 1 -> DONE.
  - eop = 1 and byte_count == 0 -> ERR_IDLE (empty packet).
  - eop = 0 -> ERR_IDLE (single-bit SE0).
- DONE: one cycle, then -> IDLE.
- ERR_WAIT: waits for se, then -> ERR_IDLE.
- ERR_IDLE: rcving = 0. d_edge -> SYNC_WAIT, which clears r_error.
- byte_count holds its value after DONE or an error until the next SYNC_WAIT entry. It never exceeds MAX_BYTES.

## Timing
- Reset: state IDLE, bit_cnt = 0, byte_count = 0; rcving, w_enable, r_error and packet_done all 0. Reset is asynchronous; any state is abandoned immediately.
- d_edge in IDLE or ERR_IDLE at cycle N -> rcving = 1 at N+1.
- byte_received for SYNC at cycle N -> SYNC_CHECK at N+1 -> DATA_WAIT (or ERR_WAIT, r_error = 1) at N+2.
- byte_received in DATA_WAIT at cycle N -> w_enable = 1 during N+1 with rcv_data still valid (the shift register does not shift for at least 8 clocks). byte_count updates at N+2.
- Second EOP sample at cycle N -> packet_done = 1 and rcving = 0 at N+1; state is IDLE at N+2.
- Inputs arriving in STORE, SYNC_CHECK or DONE are ignored. Upstream guarantees at least 8 clocks between shift_enable pulses, so no event is lost.
- d_edge pulses outside IDLE and ERR_IDLE are ignored.

## Test plan
- Clean packet: SYNC 0x80, then bytes 0xC3, 0x12, 0x34, then two eop samples -> three w_enable pulses with matching rcv_data; byte_count = 3; packet_done pulse; r_error = 0; rcving drops the cycle after the second EOP sample.
- Bad SYNC: first byte 0x81 -> r_error = 1 two cycles later, no w_enable; rcving stays 1 until se, then 0; a new d_edge clears r_error.
- Mid-byte EOP: SYNC, one byte, then se after 3 bits -> ERR_WAIT then ERR_IDLE; byte_count = 1; packet_done never asserted.
- Overflow with MAX_BYTES = 4: SYNC plus 5 bytes -> exactly 4 w_enable pulses; r_error on the 5th byte_received; byte_count = 4.
- EOP edge cases:
  - Single-bit SE0 (eop drops before the next shift_enable) -> ERR_IDLE.
  - SYNC followed immediately by EOP -> ERR_IDLE, byte_count = 0.
- Reset mid-packet: assert n_rst low during STORE -> w_enable, rcving, r_error and byte_count are 0 immediately; the next packet is received normally after reset release.
